// File: rtl/block_game_pkg.sv
// Shared types and screen constants for the falling-block game controller.
package block_game_pkg;

    typedef logic [9:0] coord_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPAWN = 2'd1,
        FALL  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam coord_t Y_MAX  = 10'd479;
    localparam coord_t PARK_Y = 10'd480;

    // Absolute difference of two coordinates, widened so it can never wrap.
    function automatic logic [10:0] abs_diff11(input coord_t a, input coord_t b);
        logic [10:0] wa;
        logic [10:0] wb;
        wa = {1'b0, a};
        wb = {1'b0, b};
        if (wa >= wb) begin
            return wa - wb;
        end else begin
            return wb - wa;
        end
    endfunction

endpackage

// File: rtl/spawn_lfsr.sv
// Free-running 10-bit LFSR (x^10 + x^7 + 1) and its fold/clamp into the
// legal spawn-column range.
module spawn_lfsr
    import block_game_pkg::*;
#(
    parameter logic [9:0] LFSR_SEED   = 10'h2A5,
    parameter coord_t     SPAWN_X_MIN = 10'd20,
    parameter coord_t     SPAWN_X_MAX = 10'd619
) (
    input  logic   Reset,
    input  logic   frame_clk,
    output coord_t spawn_x
);

    logic [9:0] lfsr_q;
    logic [9:0] lfsr_d;
    coord_t     folded;

    // Shift left, feedback from stages 10 and 7 enters at bit 0.
    always_comb begin
        lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    end

    // LFSR state; a nonzero seed keeps it off the all-zero lock-up state.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Values past the right edge fold back by 512, then the left margin is clamped.
    always_comb begin
        if (lfsr_q > SPAWN_X_MAX) begin
            folded = lfsr_q - 10'd512;
        end else begin
            folded = lfsr_q;
        end
        if (folded < SPAWN_X_MIN) begin
            spawn_x = SPAWN_X_MIN;
        end else begin
            spawn_x = folded;
        end
    end

endmodule

// File: rtl/block_spawner.sv
// Game-level controller for the falling block: spawn column, catch/miss judging, score.
// Build option BLOCK_SPAWNER_SPEEDUP_EN shortens the inter-block gap on every catch.
module block_spawner
    import block_game_pkg::*;
#(
    parameter coord_t     SPAWN_Y     = 10'd0,
    parameter coord_t     SPAWN_X_MIN = 10'd20,
    parameter coord_t     SPAWN_X_MAX = 10'd619,
    parameter coord_t     CATCH_Y     = 10'd440,
    parameter coord_t     CATCH_WIN   = 10'd4,
    parameter coord_t     CATCH_HALF  = 10'd36,
    parameter logic [7:0] GAP_FRAMES  = 8'd60,
    parameter logic [7:0] GAP_MIN     = 8'd8,
    parameter logic [3:0] MAX_MISSES  = 4'd3,
    parameter logic [9:0] LFSR_SEED   = 10'h2A5
) (
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       Start,
    input  logic [9:0] BlockX,
    input  logic [9:0] BlockY,
    input  logic [9:0] Paddle_X,
    output logic       Block_Reset,
    output logic [9:0] Block_X_Center,
    output logic [9:0] Block_Y_Center,
    output logic [7:0] Score,
    output logic [3:0] Misses,
    output logic       Game_Over,
    output logic       Active
);

    state_t     state_q;
    logic       block_reset_q;
    coord_t     x_center_q;
    coord_t     y_center_q;
    logic [7:0] score_q;
    logic [3:0] misses_q;
    logic       game_over_q;
    logic       active_q;
    logic [7:0] gap_cnt_q;
    logic [7:0] gap_len_q;

    coord_t     spawn_x;
    logic       in_window;
    logic       caught;
    logic       missed;
    logic [3:0] misses_d;
    logic [7:0] score_d;
    logic [7:0] gap_load_d;

    spawn_lfsr #(
        .LFSR_SEED   (LFSR_SEED),
        .SPAWN_X_MIN (SPAWN_X_MIN),
        .SPAWN_X_MAX (SPAWN_X_MAX)
    ) u_lfsr (
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .spawn_x   (spawn_x)
    );

    // Catch/miss decode; the window end is compared in 11 bits so it cannot wrap.
    always_comb begin
        in_window  = (BlockY >= CATCH_Y) &&
                     ({1'b0, BlockY} < ({1'b0, CATCH_Y} + {1'b0, CATCH_WIN}));
        caught     = in_window && (abs_diff11(BlockX, Paddle_X) <= {1'b0, CATCH_HALF});
        missed     = (BlockY > Y_MAX);
        misses_d   = misses_q + 4'd1;
        score_d    = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
        gap_load_d = (gap_len_q == 8'd0) ? 8'd0 : gap_len_q - 8'd1;
    end

`ifdef BLOCK_SPAWNER_SPEEDUP_EN
    logic [7:0] gap_len_short_d;

    // Next gap after a catch: four frames shorter, floored at GAP_MIN.
    always_comb begin
        if ({1'b0, gap_len_q} >= ({1'b0, GAP_MIN} + 9'd4)) begin
            gap_len_short_d = gap_len_q - 8'd4;
        end else begin
            gap_len_short_d = GAP_MIN;
        end
    end
`endif

    // Game FSM; every output is registered with the value of the state being entered.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= IDLE;
            block_reset_q <= 1'b1;
            x_center_q    <= SPAWN_X_MIN;
            y_center_q    <= PARK_Y;
            score_q       <= 8'd0;
            misses_q      <= 4'd0;
            game_over_q   <= 1'b0;
            active_q      <= 1'b0;
            gap_cnt_q     <= 8'd0;
            gap_len_q     <= GAP_FRAMES;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        score_q       <= 8'd0;
                        misses_q      <= 4'd0;
                        game_over_q   <= 1'b0;
                        gap_len_q     <= GAP_FRAMES;
                        state_q       <= SPAWN;
                        block_reset_q <= 1'b1;
                        x_center_q    <= spawn_x;
                        y_center_q    <= SPAWN_Y;
                        active_q      <= 1'b1;
                    end else begin
                        block_reset_q <= 1'b1;
                        y_center_q    <= PARK_Y;
                        active_q      <= 1'b0;
                    end
                end
                SPAWN: begin
                    state_q       <= FALL;
                    block_reset_q <= 1'b0;
                    active_q      <= 1'b1;
                end
                FALL: begin
                    if (caught) begin
                        score_q       <= score_d;
`ifdef BLOCK_SPAWNER_SPEEDUP_EN
                        gap_len_q     <= gap_len_short_d;
`endif
                        gap_cnt_q     <= gap_load_d;
                        state_q       <= GAP;
                        block_reset_q <= 1'b1;
                        y_center_q    <= PARK_Y;
                        active_q      <= 1'b0;
                    end else if (missed) begin
                        misses_q      <= misses_d;
                        block_reset_q <= 1'b1;
                        y_center_q    <= PARK_Y;
                        active_q      <= 1'b0;
                        if (misses_d == MAX_MISSES) begin
                            game_over_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            gap_cnt_q   <= gap_load_d;
                            state_q     <= GAP;
                        end
                    end else begin
                        state_q <= FALL;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == 8'd0) begin
                        state_q       <= SPAWN;
                        block_reset_q <= 1'b1;
                        x_center_q    <= spawn_x;
                        y_center_q    <= SPAWN_Y;
                        active_q      <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    block_reset_q <= 1'b1;
                    y_center_q    <= PARK_Y;
                    active_q      <= 1'b0;
                end
            endcase
        end
    end

    assign Block_Reset    = block_reset_q;
    assign Block_X_Center = x_center_q;
    assign Block_Y_Center = y_center_q;
    assign Score          = score_q;
    assign Misses         = misses_q;
    assign Game_Over      = game_over_q;
    assign Active         = active_q;

endmodule

// File: tb/tb_block_spawner.sv
// Self-checking bench for block_spawner: models the falling block at 1 px/frame
// and scores each block's outcome and gap length against a queue of expectations.
`timescale 1ns/1ps
module tb_block_spawner;

    logic       Reset;
    logic       frame_clk;
    logic       Start;
    logic [9:0] BlockX;
    logic [9:0] BlockY;
    logic [9:0] Paddle_X;
    logic       Block_Reset;
    logic [9:0] Block_X_Center;
    logic [9:0] Block_Y_Center;
    logic [7:0] Score;
    logic [3:0] Misses;
    logic       Game_Over;
    logic       Active;

    block_spawner dut (
        .Reset          (Reset),
        .frame_clk      (frame_clk),
        .Start          (Start),
        .BlockX         (BlockX),
        .BlockY         (BlockY),
        .Paddle_X       (Paddle_X),
        .Block_Reset    (Block_Reset),
        .Block_X_Center (Block_X_Center),
        .Block_Y_Center (Block_Y_Center),
        .Score          (Score),
        .Misses         (Misses),
        .Game_Over      (Game_Over),
        .Active         (Active)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    int checks = 0;
    int passed = 0;

    typedef struct {
        int score;
        int misses;
        bit over;
        int gap;
        int y_after;
    } exp_t;
    exp_t sb[$];

    int m_score   = 0;
    int m_misses  = 0;
    int m_gap_len = 60;

    // Reference LFSR: x^10 + x^7 + 1 from seed 0x2A5; lfsr_prev holds the pre-edge value.
    logic [9:0] lfsr_m;
    logic [9:0] lfsr_prev;
    always @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            lfsr_m    <= 10'h2A5;
            lfsr_prev <= 10'h2A5;
        end else begin
            lfsr_prev <= lfsr_m;
            lfsr_m    <= {lfsr_m[8:0], lfsr_m[9] ^ lfsr_m[6]};
        end
    end

    function automatic logic [9:0] map_x(input logic [9:0] r);
        logic [9:0] x;
        x = (r > 10'd619) ? r - 10'd512 : r;
        if (x < 10'd20) x = 10'd20;
        return x;
    endfunction

    int lfsr_err   = 0;
    int range_err  = 0;
    int lfsr_zero  = 0;
    int lfsr_frames = 0;
    always @(negedge frame_clk) begin
        if (!Reset) begin
            lfsr_frames <= lfsr_frames + 1;
            if (dut.u_lfsr.spawn_x !== map_x(lfsr_m)) lfsr_err <= lfsr_err + 1;
            if (dut.u_lfsr.spawn_x < 10'd20 || dut.u_lfsr.spawn_x > 10'd619) range_err <= range_err + 1;
            if (lfsr_m == 10'd0) lfsr_zero <= lfsr_zero + 1;
        end
    end

    // One frame: the block model follows Block_Reset/Block_Y_Center as seen before the edge.
    task automatic step();
        logic       br;
        logic [9:0] yc;
        br = Block_Reset;
        yc = Block_Y_Center;
        @(posedge frame_clk);
        #1;
        BlockY = br ? yc : BlockY + 10'd1;
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if ({Block_Reset, Block_X_Center, Block_Y_Center, Score, Misses, Game_Over, Active} !==
            {1'b1, 10'd20, 10'd480, 8'd0, 4'd0, 1'b0, 1'b0}) begin
            $display("FAIL %s: got br=%0b x=%0d y=%0d score=%0d miss=%0d over=%0b act=%0b, want 1/20/480/0/0/0/0",
                     tag, Block_Reset, Block_X_Center, Block_Y_Center, Score, Misses, Game_Over, Active);
        end else passed++;
    endtask

    // Called just after the edge that should enter SPAWN; leaves the DUT just into FALL.
    task automatic expect_spawn(input string tag);
        logic [9:0] exp_x;
        exp_x = map_x(lfsr_prev);
        checks++;
        if ({Active, Block_Reset, Block_Y_Center} !== {1'b1, 1'b1, 10'd0}) begin
            $display("FAIL %s_spawn: got act=%0b br=%0b y=%0d, want 1/1/0", tag, Active, Block_Reset, Block_Y_Center);
        end else passed++;
        checks++;
        if (Block_X_Center !== exp_x) begin
            $display("FAIL %s_spawn_x: got %0d, want %0d", tag, Block_X_Center, exp_x);
        end else passed++;
        step();
        checks++;
        if ({Active, Block_Reset, Block_X_Center} !== {1'b1, 1'b0, exp_x}) begin
            $display("FAIL %s_fall: got act=%0b br=%0b x=%0d, want 1/0/%0d", tag, Active, Block_Reset, Block_X_Center, exp_x);
        end else passed++;
    endtask

    // Drop one block from FALL entry; predicts outcome and following gap into the scoreboard.
    task automatic play_block(input string tag, input logic [9:0] bx, input logic [9:0] px);
        exp_t e;
        int   dx;
        int   n;
        int   g;
        bit   parked;
        BlockX   = bx;
        Paddle_X = px;
        dx = (int'(bx) > int'(px)) ? int'(bx) - int'(px) : int'(px) - int'(bx);
        if (dx <= 36) begin
            m_score   = (m_score == 255) ? 255 : m_score + 1;
            e.gap     = (m_gap_len == 0) ? 1 : m_gap_len;
            e.over    = 1'b0;
            e.y_after = 441;
`ifdef BLOCK_SPAWNER_SPEEDUP_EN
            m_gap_len = (m_gap_len - 4 < 8) ? 8 : m_gap_len - 4;
`endif
        end else begin
            m_misses  = m_misses + 1;
            e.over    = (m_misses == 3);
            e.gap     = (m_gap_len == 0) ? 1 : m_gap_len;
            e.y_after = 481;
        end
        e.score  = m_score;
        e.misses = m_misses;
        sb.push_back(e);

        n = 0;
        while (Active === 1'b1 && n < 700) begin
            step();
            n++;
        end
        e = sb.pop_front();
        checks++;
        if (n >= 700) begin
            $display("FAIL %s_timeout: block never resolved within 700 frames", tag);
            return;
        end else passed++;
        checks++;
        if ({Score, Misses, Game_Over} !== {e.score[7:0], e.misses[3:0], e.over}) begin
            $display("FAIL %s_outcome: got score=%0d miss=%0d over=%0b, want %0d/%0d/%0b",
                     tag, Score, Misses, Game_Over, e.score, e.misses, e.over);
        end else passed++;
        checks++;
        if ({Block_Reset, Block_Y_Center, BlockY} !== {1'b1, 10'd480, e.y_after[9:0]}) begin
            $display("FAIL %s_park: got br=%0b yc=%0d blocky=%0d, want 1/480/%0d",
                     tag, Block_Reset, Block_Y_Center, BlockY, e.y_after);
        end else passed++;
        if (e.over) return;

        g = 0;
        parked = 1'b1;
        while (Active !== 1'b1 && g < 300) begin
            if (Block_Reset !== 1'b1 || Block_Y_Center !== 10'd480) parked = 1'b0;
            step();
            g++;
        end
        checks++;
        if (g != e.gap || !parked) begin
            $display("FAIL %s_gap: got %0d frames parked=%0b, want %0d parked=1", tag, g, parked, e.gap);
        end else passed++;
        if (g < 300) expect_spawn(tag);
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        step();
        Start = 1'b0;
        m_score   = 0;
        m_misses  = 0;
        m_gap_len = 60;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0;
        BlockX = 10'd300; BlockY = 10'd480; Paddle_X = 10'd320;
        repeat (2) @(posedge frame_clk);
        #1;
        check_reset_values("reset");
        @(negedge frame_clk);
        Reset = 1'b0;
        repeat (3) step();
        check_reset_values("idle_no_start");
    endtask

    task automatic test_start_spawn();
        pulse_start();
        expect_spawn("start");
    endtask

    task automatic test_catch_and_miss();
        play_block("catch_basic", 10'd300, 10'd320);
        play_block("miss_basic", 10'd100, 10'd500);
        play_block("catch_edge_left", 10'd264, 10'd300);
        play_block("catch_edge_right", 10'd336, 10'd300);
        play_block("miss_edge", 10'd337, 10'd300);
    endtask

    task automatic test_game_over();
        play_block("miss_final", 10'd0, 10'd1023);
        checks++;
        if ({Active, Block_Reset, Game_Over, Misses} !== {1'b0, 1'b1, 1'b1, 4'd3}) begin
            $display("FAIL game_over: got act=%0b br=%0b over=%0b miss=%0d, want 0/1/1/3",
                     Active, Block_Reset, Game_Over, Misses);
        end else passed++;
        repeat (70) step();
        checks++;
        if ({Active, Game_Over} !== {1'b0, 1'b1}) begin
            $display("FAIL idle_hold: got act=%0b over=%0b, want 0/1", Active, Game_Over);
        end else passed++;
        pulse_start();
        checks++;
        if ({Score, Misses, Game_Over} !== {8'd0, 4'd0, 1'b0}) begin
            $display("FAIL restart_clear: got score=%0d miss=%0d over=%0b, want 0/0/0", Score, Misses, Game_Over);
        end else passed++;
        expect_spawn("restart");
    endtask

    task automatic test_reset_mid_fall();
        int n;
        play_block("catch_pre_reset", 10'd310, 10'd300);
        n = 0;
        while (BlockY !== 10'd200 && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (n >= 300 || Active !== 1'b1 || Score !== 8'd1) begin
            $display("FAIL mid_fall_setup: got blocky=%0d act=%0b score=%0d, want 200/1/1", BlockY, Active, Score);
        end else passed++;
        #2;
        Reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        @(negedge frame_clk);
        Reset = 1'b0;
        pulse_start();
        expect_spawn("post_reset");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 15; i++) begin
            play_block($sformatf("gap_run%0d", i), 10'd300, 10'd300);
        end
    endtask

    task automatic test_lfsr();
        checks++;
        if (lfsr_frames < 1023 || lfsr_err != 0 || lfsr_zero != 0) begin
            $display("FAIL lfsr_seq: got frames=%0d mismatches=%0d zero_states=%0d, want >=1023/0/0",
                     lfsr_frames, lfsr_err, lfsr_zero);
        end else passed++;
        checks++;
        if (range_err != 0) begin
            $display("FAIL lfsr_range: got %0d spawn X values outside [20,619], want 0", range_err);
        end else passed++;
    endtask

    initial begin
        test_reset();
        test_start_spawn();
        test_catch_and_miss();
        test_game_over();
        test_reset_mid_fall();
        test_back_to_back();
        test_lfsr();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
